// File: rtl/test_monitor.sv
// test_monitor: end-of-test monitor for a RISC-V core simulation.
// It snoops the register-file writeback, shadows x3 (test number),
// x26 (end flag) and x27 (result), and produces a sticky verdict.
//
// After an x26 := 1 write it waits DRAIN_CYCLES edges, then samples x27:
// a value of 1 gives pass, anything else gives fail. If no end flag is
// seen within TIMEOUT_CYCLES edges in RUN, the verdict is timeout.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   we_i       register-file write enable
//   waddr_i    register-file write address (5 bits)
//   wdata_i    register-file write data (32 bits)
//   done_o     verdict available (sticky until reset)
//   pass_o     program ended with x27 == 1
//   fail_o     program ended with x27 != 1
//   timeout_o  end flag not seen in time
//   testnum_o  x3 value latched with the verdict
module test_monitor #(
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] testnum_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [31:0] cyc;
  logic [7:0]  drain;
  logic [31:0] x3, x26, x27;

  // Address 0 never matches any shadow, so x0 writes are naturally ignored.
  logic        w3, w26, w27;
  logic [31:0] x3_nxt, x26_nxt, x27_nxt;
  logic        end_flag;

  assign w3  = we_i && (waddr_i == 5'd3);
  assign w26 = we_i && (waddr_i == 5'd26);
  assign w27 = we_i && (waddr_i == 5'd27);

  // Next-values include a write presented in the current cycle, so a
  // write on the very edge that closes the verdict still counts.
  assign x3_nxt  = w3  ? wdata_i : x3;
  assign x26_nxt = w26 ? wdata_i : x26;
  assign x27_nxt = w27 ? wdata_i : x27;

  // End flag: this cycle's x26 write carries the value 1.
  assign end_flag = w26 && (x26_nxt == 32'd1);

  assign done_o = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cyc       <= '0;
      drain     <= '0;
      x3        <= '0;
      x26       <= '0;
      x27       <= '0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      testnum_o <= '0;
    end else begin
      // Shadows track the register file in every state.
      x3  <= x3_nxt;
      x26 <= x26_nxt;
      x27 <= x27_nxt;
      case (state)
        RUN: begin
          cyc <= cyc + 32'd1;
          // End flag wins over a coincident timeout.
          if (end_flag) begin
            state <= DRAIN;
            drain <= DRAIN_LOAD;
          end else if (cyc == TO_LAST) begin
            state     <= DONE;
            timeout_o <= 1'b1;
            testnum_o <= x3_nxt;
          end
        end
        DRAIN: begin
          // Further end-flag writes are ignored here; the count never restarts.
          if (drain == 8'd0) begin
            state     <= DONE;
            pass_o    <= (x27_nxt == 32'd1);
            fail_o    <= (x27_nxt != 32'd1);
            testnum_o <= x3_nxt;
          end else begin
            drain <= drain - 8'd1;
          end
        end
        DONE: ;  // verdict held until reset
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 5, giving the cycles waited after the end flag before the verdict is sampled; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the cycles in RUN before a timeout verdict; legal range 2..2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port we_i, input, 1 bit: register-file write enable, snooped from the core writeback.
REQ-006 SHALL have port waddr_i, input, 5 bits: register-file write address.
REQ-007 SHALL have port wdata_i, input, 32 bits: register-file write data.
REQ-008 SHALL have port done_o, output, 1 bit: a verdict is available; sticky.
REQ-009 SHALL have port pass_o, output, 1 bit: the program ended with x27 == 1.
REQ-010 SHALL have port fail_o, output, 1 bit: the program ended with x27 != 1.
REQ-011 SHALL have port timeout_o, output, 1 bit: the end flag was not seen within TIMEOUT_CYCLES.
REQ-012 SHALL have port testnum_o, output, 32 bits: x3 value latched at the verdict.

Function
REQ-013 SHALL keep 32-bit shadow copies of x3, x26 and x27.
- A shadow is loaded from wdata_i on any edge where we_i=1 and waddr_i matches that register.
- Shadow updates continue in every state, including DONE.
REQ-014 SHALL implement a state machine with three states: RUN, DRAIN and DONE.
REQ-015 SHALL, in RUN, increment a 32-bit cycle counter on every edge.
REQ-016 SHALL move RUN->DRAIN on the edge where we_i=1, waddr_i=26 and wdata_i=32'h1.
- The drain counter is loaded with DRAIN_CYCLES-1 on that edge.
REQ-017 SHALL move RUN->DONE with timeout on the edge where the cycle counter equals TIMEOUT_CYCLES-1 and the RUN->DRAIN condition is false.
- On that edge it SHALL register timeout_o=1, pass_o=0, fail_o=0, and testnum_o = x3 shadow next-value.
REQ-018 SHALL give the end-flag write priority when it coincides with the timeout edge; that case goes to DRAIN.
REQ-019 SHALL, in DRAIN, decrement the drain counter on each edge.
- On the edge where the counter is 0, it SHALL go to DONE.
- On that edge it SHALL register pass_o = (x27 next-value == 1), fail_o = ~pass_o, and testnum_o = x3 next-value.
- Next-value includes a write presented in that same cycle.
REQ-020 SHALL assert done_o exactly when the state is DONE.
REQ-021 SHALL satisfy this latency: for an end-flag write sampled at edge E, done_o rises after edge E+DRAIN_CYCLES.
REQ-022 SHALL ignore further x26=1 writes while in DRAIN; the drain counter does not restart.
REQ-023 SHALL treat writes of x26 with values other than 1 as shadow updates only.
REQ-024 SHALL hold DONE and all verdict outputs (pass_o, fail_o, timeout_o, testnum_o) until reset; later writes never change the outputs.
REQ-025 SHALL guarantee that at most one of pass_o, fail_o, timeout_o is 1 at any time, and that all three are 0 while done_o=0.
REQ-026 SHALL treat waddr_i=0 writes as no-ops for all shadows.

Reset
REQ-027 SHALL, while rst=1, immediately force the following, independent of clk:
- state=RUN;
- cycle counter, drain counter and all shadows = 0;
- done_o=0, pass_o=0, fail_o=0, timeout_o=0, testnum_o=0.
REQ-028 SHALL start counting from 0 on the first rising edge after rst deasserts.
REQ-029 SHALL, when rst asserts in DRAIN or DONE, discard all progress and verdicts and restart monitoring in RUN after release.

Verification (DRAIN_CYCLES=5, TIMEOUT_CYCLES=100)
REQ-030 SHALL cover pass: write x3=7, x27=1, then x26=1 at edge E -> done_o rises after E+5, pass_o=1, fail_o=0, timeout_o=0, testnum_o=7.
REQ-031 SHALL cover fail with a late write: x27=0, x3=12, x26=1 at E, then x27=1 at E+5 -> pass_o=1 (last-cycle write counts); with x27=1 written at E+6 instead -> fail_o=1, testnum_o=12.
REQ-032 SHALL cover timeout: no x26 write after reset -> after edge 99, done_o=1, timeout_o=1, pass_o=fail_o=0; writing x26=1 at edge 99 instead -> DRAIN, no timeout.
REQ-033 SHALL cover decoys: writes x26=2, x26=1 with we_i=0, and waddr_i=0 with data 1 -> state stays RUN; a second x26=1 during DRAIN -> done_o still rises after E+5.
REQ-034 SHALL cover mid-operation reset: assert rst two cycles into DRAIN -> all outputs 0 immediately; after release, a fresh pass sequence yields a correct verdict.
REQ-035 SHALL cover stickiness: after DONE with pass_o=1, write x27=0 and x26=1 -> outputs unchanged for 20 cycles.
